// File: rtl/cmd_responder_if.sv
// Command/reply byte streams and register bus between the FX2 host side and cmd_responder.
interface cmd_responder_if;
    logic        cmd_wr;
    logic [7:0]  cmd_in;
    logic        reply_rdy;
    logic [7:0]  reply;
    logic        reply_ack;
    logic        reply_end;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;

    modport slave (
        input  cmd_wr, cmd_in, reply_ack, reg_rdata,
        output reply_rdy, reply, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport master (
        output cmd_wr, cmd_in, reply_ack, reg_rdata,
        input  reply_rdy, reply, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/cmd_responder.sv
// Parses host register read/write frames from the command byte stream, drives the
// register bus and streams read data back as a 4-byte little-endian reply.
module cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  ERR_BYTE       = 8'hFF
) (
    input  logic                   fx2_clk,
    input  logic                   reset_n,
    cmd_responder_if.slave         bus,
    output logic                   busy,
    output logic [7:0]             err_count
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_DATA,
        S_WR_ISSUE, S_RD_ISSUE, S_RD_CAPTURE, S_REPLY
    } state_t;

    state_t      r_state;
    logic        r_is_wr;
    logic [1:0]  r_cnt;
    logic [1:0]  r_idx;
    logic [TW-1:0] r_tmo;
    logic [15:0] r_addr_buf;
    logic [31:0] r_wdata_buf;
    logic [31:0] r_rdata;
    logic        r_reply_rdy;
    logic [7:0]  r_reply;
    logic        r_reply_end;
    logic [15:0] r_reg_addr;
    logic [31:0] r_reg_wdata;
    logic        r_reg_wr;
    logic        r_reg_rd;
    logic [7:0]  r_err;

    logic        w_in_frame;
    logic        w_blocked;
    logic        w_bad_op;
    logic        w_tmo;
    logic        w_err;
    logic [1:0]  w_next_idx;
    logic [7:0]  w_next_byte;

    always_comb begin
        w_in_frame  = (r_state == S_ADDR_LO) || (r_state == S_ADDR_HI) || (r_state == S_DATA);
        w_blocked   = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE) ||
                      (r_state == S_RD_CAPTURE) || (r_state == S_REPLY);
        w_bad_op    = (r_state == S_IDLE) && bus.cmd_wr && (bus.cmd_in > 8'h02);
        w_tmo       = (TIMEOUT_CYCLES != 0) && w_in_frame && !bus.cmd_wr &&
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));
        // All error sources fold into one increment per cycle
        w_err       = w_bad_op || (w_blocked && bus.cmd_wr) || w_tmo;
        w_next_idx  = r_idx + 2'd1;
        w_next_byte = r_rdata[{w_next_idx, 3'b000} +: 8];
    end

    always_ff @(posedge fx2_clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_addr_buf  <= '0;
            r_wdata_buf <= '0;
            r_rdata     <= '0;
            r_reply_rdy <= 1'b0;
            r_reply     <= '0;
            r_reply_end <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_err       <= '0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_wr) begin
                        r_tmo <= '0;
                        case (bus.cmd_in)
                            8'h00: ;
                            8'h01: begin r_is_wr <= 1'b0; r_state <= S_ADDR_LO; end
                            8'h02: begin r_is_wr <= 1'b1; r_state <= S_ADDR_LO; end
                            default: begin
                                // Error reply reuses REPLY as a single last byte
                                r_reply     <= ERR_BYTE;
                                r_reply_rdy <= 1'b1;
                                r_reply_end <= 1'b1;
                                r_idx       <= 2'd3;
                                r_state     <= S_REPLY;
                            end
                        endcase
                    end
                end
                S_ADDR_LO: begin
                    if (bus.cmd_wr) begin
                        r_addr_buf[7:0] <= bus.cmd_in;
                        r_tmo           <= '0;
                        r_state         <= S_ADDR_HI;
                    end else if (w_tmo) r_state <= S_IDLE;
                    else r_tmo <= r_tmo + 1'b1;
                end
                S_ADDR_HI: begin
                    if (bus.cmd_wr) begin
                        r_addr_buf[15:8] <= bus.cmd_in;
                        r_tmo            <= '0;
                        if (r_is_wr) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_reg_addr <= {bus.cmd_in, r_addr_buf[7:0]};
                            r_reg_rd   <= 1'b1;
                            r_state    <= S_RD_ISSUE;
                        end
                    end else if (w_tmo) r_state <= S_IDLE;
                    else r_tmo <= r_tmo + 1'b1;
                end
                S_DATA: begin
                    if (bus.cmd_wr) begin
                        r_tmo <= '0;
                        if (r_cnt == 2'd3) begin
                            r_reg_addr  <= r_addr_buf;
                            r_reg_wdata <= {bus.cmd_in, r_wdata_buf[23:0]};
                            r_reg_wr    <= 1'b1;
                            r_state     <= S_WR_ISSUE;
                        end else begin
                            r_wdata_buf[{r_cnt, 3'b000} +: 8] <= bus.cmd_in;
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end else if (w_tmo) r_state <= S_IDLE;
                    else r_tmo <= r_tmo + 1'b1;
                end
                S_WR_ISSUE:   r_state <= S_IDLE;
                S_RD_ISSUE:   r_state <= S_RD_CAPTURE;
                S_RD_CAPTURE: begin
                    r_rdata     <= bus.reg_rdata;
                    r_reply     <= bus.reg_rdata[7:0];
                    r_reply_rdy <= 1'b1;
                    r_reply_end <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= S_REPLY;
                end
                S_REPLY: begin
                    if (bus.reply_ack) begin
                        if (r_idx == 2'd3) begin
                            r_reply_rdy <= 1'b0;
                            r_reply_end <= 1'b0;
                            r_reply     <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx       <= w_next_idx;
                            r_reply     <= w_next_byte;
                            r_reply_end <= (w_next_idx == 2'd3);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.reply_rdy = r_reply_rdy;
    assign bus.reply     = r_reply;
    assign bus.reply_end = r_reply_end;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_rd    = r_reg_rd;
    assign busy          = (r_state != S_IDLE);
    assign err_count     = r_err;
endmodule

// File: doc/cmd_responder.md
Name: cmd_responder

Overview:
- Host-command responder on the command/reply channel of the FX2 bidirectional interface.
- Consumes the command byte stream (cmd_wr/cmd_in) and parses register read/write frames.
- Drives a simple register bus into the timetag core and returns read data as a reply byte stream (reply_rdy/reply/reply_ack/reply_end).
- Entirely in the fx2_clk domain.

Parameters:
- TIMEOUT_CYCLES, 65535: idle cycles allowed between bytes of one frame before the frame is abandoned; 0 disables the timeout.
- ERR_BYTE, 8'hFF: single-byte reply sent for an unknown opcode.

Ports:
- fx2_clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- cmd_wr  in  1  one-cycle strobe; cmd_in is valid this cycle.
- cmd_in  in  8  command byte.
- reply_rdy  out  1  reply byte valid.
- reply  out  8  reply byte.
- reply_ack  in  1  consumer takes the byte on a cycle where reply_rdy&reply_ack.
- reply_end  out  1  high with the last byte of a reply.
- reg_addr  out  16  register address.
- reg_wdata  out  32  register write data.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, valid exactly 1 cycle after reg_rd.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating error counter.

Behaviour:
- Reset (reset_n=0 at an edge) applies in any state, including mid-frame or mid-reply:
  - Outputs 0: reply_rdy, reply, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err_count.
  - State goes to IDLE; any partial frame or reply is discarded with no reg strobe.
- Frame format, bytes little-endian:
  - Read: 0x01, A[7:0], A[15:8].
  - Write: 0x02, A[7:0], A[15:8], D[7:0], D[15:8], D[23:16], D[31:24].
  - 0x00 is a NOP: consumed and ignored, no reply.
  - Any other opcode: reply ERR_BYTE (one byte, reply_end=1) and err_count++.
- States and transitions:
  - IDLE: on cmd_wr, decode opcode.
  - ADDR_LO -> ADDR_HI: one cmd_wr each.
  - After ADDR_HI: write frame -> DATA (byte counter 0..3); read frame -> RD_ISSUE.
  - DATA: the 4th byte goes to WR_ISSUE.
  - WR_ISSUE: reg_wr=1 for one cycle, then IDLE. No reply is sent for a write.
  - RD_ISSUE: reg_rd=1 for one cycle -> RD_CAPTURE.
  - RD_CAPTURE: latch reg_rdata -> REPLY.
  - REPLY: present bytes D[7:0]..D[31:24] in order; reply_end=1 with byte 3.
- Latency:
  - Read: last address byte's cmd_wr at cycle T; reg_rd at T+1; capture at T+2; reply_rdy=1 with byte 0 at T+3.
  - Write: last data byte at T; reg_wr at T+1; IDLE at T+2.
- reg_addr and reg_wdata stay stable from the strobe cycle until the next frame modifies them.
- Reply handshake:
  - A byte is held until acked.
  - After an ack the next byte appears on the following cycle, with reply_rdy staying high.
  - After the last ack, reply_rdy and reply_end go 0 on the next cycle and the state returns to IDLE.
  - reply_ack while reply_rdy=0 is ignored.
- cmd_wr arriving in WR_ISSUE, RD_ISSUE, RD_CAPTURE or REPLY: byte dropped, err_count++. The state machine is unaffected.
- Timeout:
  - Applies in ADDR_LO, ADDR_HI and DATA only.
  - The counter resets on each cmd_wr.
  - Reaching TIMEOUT_CYCLES without a byte returns to IDLE with no strobe, and err_count++.
- err_count:
  - Saturates at 255; never wraps.
  - Simultaneous error sources in one cycle count once.

Test Plan:
- Write frame 02 34 12 EF BE AD DE on consecutive cmd_wr -> reg_wr one cycle, reg_addr=16'h1234, reg_wdata=32'hDEADBEEF; no reply_rdy; busy low 2 cycles after the last byte.
- Read frame 01 10 00, reg_rdata=32'hCAFEF00D, reply_ack held high:
  - reg_rd 1 cycle after the last byte, reg_addr=16'h0010.
  - Reply bytes 0D F0 FE CA on 4 consecutive cycles starting 3 cycles after the last byte; reply_end only with CA.
- Read with reply_ack delayed 5 cycles per byte -> each byte held stable until acked; then issue 0x55 during REPLY -> byte dropped, err_count=1, reply bytes unchanged.
- Opcode 0x7E -> single reply ERR_BYTE 0xFF with reply_end=1, err_count++; opcode 0x00 -> no reply, no error.
- TIMEOUT_CYCLES=8: send 02 34 then stall 8 cycles -> IDLE, no reg_wr, err_count++; a following full read frame completes normally.
- Assert reset_n=0 for 1 cycle during REPLY byte 2 -> next cycle all outputs 0, state IDLE; err_count forced 0; 300 bad opcodes -> err_count holds 255.
